// File: rtl/regfile_mp.sv
// Multi-port integer register file: NRD registered read ports with same-cycle write bypass,
// NWR write ports (highest index wins), optional hardwired x0, and a sequential clear sweep after reset.
module regfile_mp #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int NRD      = 2,
    parameter int NWR      = 2,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(NREGS)
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic [NRD-1:0]      i_rd_en,
    input  logic [NRD*AW-1:0]   i_rd_addr,
    output logic [NRD*XLEN-1:0] o_rd_data,
    input  logic [NWR-1:0]      i_wr_en,
    input  logic [NWR*AW-1:0]   i_wr_addr,
    input  logic [NWR*XLEN-1:0] i_wr_data,
    output logic                o_ready,
    output logic                o_dbg_state
);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t          state;
    logic [AW-1:0]   cnt;
    logic [XLEN-1:0] mem [NREGS];
    logic [XLEN-1:0] rd_next [NRD];

    assign o_dbg_state = (state == ST_RUN);

    // Read value as it will stand after this cycle's writes; later ports override earlier ones.
    always_comb begin
        for (int k = 0; k < NRD; k++) begin
            rd_next[k] = mem[i_rd_addr[k*AW +: AW]];
            for (int j = 0; j < NWR; j++) begin
                if (i_wr_en[j] && (i_wr_addr[j*AW +: AW] == i_rd_addr[k*AW +: AW])) begin
                    rd_next[k] = i_wr_data[j*XLEN +: XLEN];
                end
            end
            if ((ZERO_REG != 0) && (i_rd_addr[k*AW +: AW] == '0)) begin
                rd_next[k] = '0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state     <= ST_INIT;
            cnt       <= '0;
            o_ready   <= 1'b0;
            o_rd_data <= '0;
        end else begin
            case (state)
                ST_INIT: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == AW'(NREGS - 1)) begin
                        state   <= ST_RUN;
                        o_ready <= 1'b1;
                    end
                end
                ST_RUN: begin
                    for (int k = 0; k < NRD; k++) begin
                        if (i_rd_en[k]) begin
                            o_rd_data[k*XLEN +: XLEN] <= rd_next[k];
                        end
                    end
                end
                default: state <= ST_INIT;
            endcase
        end
    end

    // Storage has no reset of its own; the INIT sweep clears one entry per cycle.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            if (state == ST_INIT) begin
                mem[cnt] <= '0;
            end else begin
                for (int j = 0; j < NWR; j++) begin
                    if (i_wr_en[j] && !((ZERO_REG != 0) && (i_wr_addr[j*AW +: AW] == '0))) begin
                        mem[i_wr_addr[j*AW +: AW]] <= i_wr_data[j*XLEN +: XLEN];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: default instance (32 regs, 2R/2W, hardwired x0) and a
// 16-reg 3R/1W instance with ordinary x0, checked through a read-data scoreboard.
module tb_regfile_mp;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [1:0]  a_rd_en = '0;
    logic [9:0]  a_rd_addr = '0;
    logic [63:0] a_rd_data;
    logic [1:0]  a_wr_en = '0;
    logic [9:0]  a_wr_addr = '0;
    logic [63:0] a_wr_data = '0;
    logic        a_ready, a_dbg;

    logic [2:0]  b_rd_en = '0;
    logic [11:0] b_rd_addr = '0;
    logic [95:0] b_rd_data;
    logic [0:0]  b_wr_en = '0;
    logic [3:0]  b_wr_addr = '0;
    logic [31:0] b_wr_data = '0;
    logic        b_ready, b_dbg;

    regfile_mp dut_a (
        .i_clk(clk), .i_reset(rst),
        .i_rd_en(a_rd_en), .i_rd_addr(a_rd_addr), .o_rd_data(a_rd_data),
        .i_wr_en(a_wr_en), .i_wr_addr(a_wr_addr), .i_wr_data(a_wr_data),
        .o_ready(a_ready), .o_dbg_state(a_dbg)
    );

    regfile_mp #(.XLEN(32), .NREGS(16), .NRD(3), .NWR(1), .ZERO_REG(0)) dut_b (
        .i_clk(clk), .i_reset(rst),
        .i_rd_en(b_rd_en), .i_rd_addr(b_rd_addr), .o_rd_data(b_rd_data),
        .i_wr_en(b_wr_en), .i_wr_addr(b_wr_addr), .i_wr_data(b_wr_data),
        .o_ready(b_ready), .o_dbg_state(b_dbg)
    );

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Scoreboard: expected read data per checked port, in cycle then port order.
    logic [31:0] exp_q[$];
    logic [31:0] exp_qb[$];
    logic [1:0]  chk_a_req = '0, chk_a_q = '0;
    logic [2:0]  chk_b_req = '0, chk_b_q = '0;

    always @(posedge clk) begin
        chk_a_q <= chk_a_req;
        chk_b_q <= chk_b_req;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %08h expected %08h", name, act, exp);
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (chk_a_q[k]) begin
                if (exp_q.size() == 0) check("a_underflow", 32'd1, 32'd0);
                else check($sformatf("a_rd%0d", k), a_rd_data[k*32 +: 32], exp_q.pop_front());
            end
        end
        for (int k = 0; k < 3; k++) begin
            if (chk_b_q[k]) begin
                if (exp_qb.size() == 0) check("b_underflow", 32'd1, 32'd0);
                else check($sformatf("b_rd%0d", k), b_rd_data[k*32 +: 32], exp_qb.pop_front());
            end
        end
    end

    task automatic a_cyc(input logic [1:0] re, input logic [4:0] r0, input logic [4:0] r1,
                         input logic [1:0] we, input logic [4:0] w0, input logic [31:0] d0,
                         input logic [4:0] w1, input logic [31:0] d1,
                         input logic [1:0] chk, input logic [31:0] e0, input logic [31:0] e1);
        a_rd_en   = re;
        a_rd_addr = {r1, r0};
        a_wr_en   = we;
        a_wr_addr = {w1, w0};
        a_wr_data = {d1, d0};
        chk_a_req = chk;
        if (chk[0]) exp_q.push_back(e0);
        if (chk[1]) exp_q.push_back(e1);
        @(posedge clk); #1;
        a_rd_en = '0; a_wr_en = '0; chk_a_req = '0;
    endtask

    task automatic b_cyc(input logic [2:0] re, input logic [3:0] r0, input logic [3:0] r1,
                         input logic [3:0] r2, input logic we, input logic [3:0] wa,
                         input logic [31:0] wd, input logic [2:0] chk,
                         input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] e2);
        b_rd_en   = re;
        b_rd_addr = {r2, r1, r0};
        b_wr_en   = we;
        b_wr_addr = wa;
        b_wr_data = wd;
        chk_b_req = chk;
        if (chk[0]) exp_qb.push_back(e0);
        if (chk[1]) exp_qb.push_back(e1);
        if (chk[2]) exp_qb.push_back(e2);
        @(posedge clk); #1;
        b_rd_en = '0; b_wr_en = '0; chk_b_req = '0;
    endtask

    // Counts posedges after reset release until each o_ready rises; -1 if the budget expires.
    task automatic wait_ready(output int ca, output int cb);
        ca = -1;
        cb = -1;
        for (int c = 1; c <= 64; c++) begin
            @(posedge clk); #1;
            if (a_ready && ca < 0) begin
                ca = c;
                a_wr_en = '0;
                a_rd_en = '0;
            end
            if (b_ready && cb < 0) cb = c;
        end
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    logic [31:0] ref_mem [16];
    logic [31:0] last [3];

    initial begin
        int ca, cb;
        pulse_reset();
        check("reset_ready_a", 32'(a_ready), 32'd0);
        check("reset_data_a", a_rd_data[31:0] | a_rd_data[63:32], 32'd0);
        check("reset_ready_b", 32'(b_ready), 32'd0);
        // Traffic during INIT must be ignored.
        a_wr_en   = 2'b11;
        a_wr_addr = {5'd2, 5'd1};
        a_wr_data = {32'h12345678, 32'h87654321};
        a_rd_en   = 2'b11;
        a_rd_addr = {5'd2, 5'd1};
        wait_ready(ca, cb);
        check("sweep_len_a", 32'(ca), 32'd32);
        check("sweep_len_b", 32'(cb), 32'd16);
        check("init_rd_a", a_rd_data[31:0] | a_rd_data[63:32], 32'd0);

        for (int i = 0; i < 16; i++)
            a_cyc(2'b11, 5'(2*i), 5'(2*i+1), 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 2'b11, 32'd0, 32'd0);

        a_cyc(2'b10, 5'd0, 5'd5, 2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'd0, 2'b10, 32'd0, 32'hDEADBEEF);
        a_cyc(2'b01, 5'd5, 5'd0, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 2'b01, 32'hDEADBEEF, 32'd0);
        a_cyc(2'b01, 5'd7, 5'd0, 2'b11, 5'd7, 32'h11111111, 5'd7, 32'h22222222, 2'b01, 32'h22222222, 32'd0);
        a_cyc(2'b10, 5'd0, 5'd7, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 2'b10, 32'd0, 32'h22222222);
        a_cyc(2'b11, 5'd0, 5'd0, 2'b10, 5'd0, 32'd0, 5'd0, 32'hFFFFFFFF, 2'b11, 32'd0, 32'd0);
        a_cyc(2'b11, 5'd0, 5'd0, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 2'b11, 32'd0, 32'd0);
        a_cyc(2'b00, 5'd0, 5'd0, 2'b01, 5'd3, 32'hA5A5A5A5, 5'd0, 32'd0, 2'b00, 32'd0, 32'd0);
        a_cyc(2'b01, 5'd3, 5'd0, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 2'b01, 32'hA5A5A5A5, 32'd0);
        a_cyc(2'b00, 5'd3, 5'd0, 2'b01, 5'd3, 32'h5A5A5A5A, 5'd0, 32'd0, 2'b01, 32'hA5A5A5A5, 32'd0);
        a_cyc(2'b00, 5'd3, 5'd3, 2'b10, 5'd0, 32'd0, 5'd3, 32'h00C0FFEE, 2'b01, 32'hA5A5A5A5, 32'd0);
        a_cyc(2'b11, 5'd3, 5'd7, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 2'b11, 32'h00C0FFEE, 32'h22222222);
        a_cyc(2'b11, 5'd9, 5'd9, 2'b11, 5'd9, 32'hAAAA0000, 5'd31, 32'hBBBB1111, 2'b11, 32'hAAAA0000, 32'hAAAA0000);
        a_cyc(2'b11, 5'd31, 5'd5, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 2'b11, 32'hBBBB1111, 32'hDEADBEEF);

        // Ordinary x0 on the 16-entry instance: bypassed and stored.
        b_cyc(3'b001, 4'd0, 4'd0, 4'd0, 1'b1, 4'd0, 32'hFFFFFFFF, 3'b111, 32'hFFFFFFFF, 32'd0, 32'd0);
        b_cyc(3'b010, 4'd0, 4'd0, 4'd0, 1'b0, 4'd0, 32'd0, 3'b111, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0);

        for (int i = 0; i < 16; i++) ref_mem[i] = '0;
        ref_mem[0] = 32'hFFFFFFFF;
        last[0] = 32'hFFFFFFFF;
        last[1] = 32'hFFFFFFFF;
        last[2] = 32'd0;
        for (int n = 0; n < 300; n++) begin
            logic [2:0]  re;
            logic [3:0]  ra [3];
            logic        we;
            logic [3:0]  wa;
            logic [31:0] wd;
            re = 3'($urandom_range(0, 7));
            for (int k = 0; k < 3; k++) ra[k] = 4'($urandom_range(0, 15));
            we = 1'($urandom_range(0, 1));
            wa = 4'($urandom_range(0, 15));
            wd = $urandom;
            for (int k = 0; k < 3; k++)
                if (re[k]) last[k] = (we && wa == ra[k]) ? wd : ref_mem[ra[k]];
            if (we) ref_mem[wa] = wd;
            b_cyc(re, ra[0], ra[1], ra[2], we, wa, wd, 3'b111, last[0], last[1], last[2]);
        end

        // Reset during the sweep restarts it from entry 0.
        pulse_reset();
        repeat (10) @(posedge clk);
        #1;
        pulse_reset();
        wait_ready(ca, cb);
        check("restart_len_a", 32'(ca), 32'd32);
        check("restart_len_b", 32'(cb), 32'd16);
        a_cyc(2'b11, 5'd5, 5'd7, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 2'b11, 32'd0, 32'd0);
        b_cyc(3'b111, 4'd0, 4'd3, 4'd15, 1'b0, 4'd0, 32'd0, 3'b111, 32'd0, 32'd0, 32'd0);

        @(posedge clk); #1;
        check("scoreboard_drained", 32'(exp_q.size() + exp_qb.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
